// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter control stage: default
// datapath width and reset PC, control state encoding, and the
// saturating retire-counter helpers.
package pc_ctrl_pkg;

    localparam int unsigned       DEF_WIDTH    = 16;
    localparam logic [15:0]       DEF_RESET_PC = 16'h0000;

    // Retired-branch counters are a fixed 16 bits regardless of PC width.
    localparam int unsigned       CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_ctrl_target_calc.sv
// Next-PC target arithmetic. Purely combinational: forms the link value
// pc+2, the PC-relative and register-indirect targets, and picks the
// next PC from the decoded jump/branch controls. Halt and stall are
// handled by the owner of the PC register, not here.
module pc_target_calc
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_WIDTH
) (
    input  logic [W-1:0] pc,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] reg_val,
    input  logic         jmp_en,
    input  logic         jmp_reg,
    input  logic         br_en,
    input  logic         br_sel,
    output logic [W-1:0] pc_plus2,
    output logic [W-1:0] next_pc,
    output logic         take
);

    logic [W-1:0] rel_target;
    logic [W-1:0] ind_target;

    // All additions wrap modulo 2^W; no carry is reported.
    assign pc_plus2   = pc + W'(2);
    assign rel_target = pc_plus2 + imm;
    assign ind_target = reg_val + imm;

    // Jump outranks branch; a jump with a branch also present still jumps.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        next_pc = pc_plus2;
        take    = 1'b0;
        if (jmp_en) begin
            take    = 1'b1;
            next_pc = jmp_reg ? ind_target : rel_target;
        end else if (br_en && br_sel) begin
            take    = 1'b1;
            next_pc = rel_target;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter control stage. Owns the fetch PC, the RUN/HALTED
// state, the saturating retired/taken branch counters and the sticky
// illegal-combination fault. Target selection lives in pc_target_calc.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned       WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_PC = DEF_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             brEn,
    input  logic             brSel,
    input  logic             jmpEn,
    input  logic             jmpReg,
    input  logic             halt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] regVal,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcPlus2,
    output logic             redirect,
    output logic             halted,
    output logic [CNT_W-1:0] brCount,
    output logic [CNT_W-1:0] brTaken,
    output logic             err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   br_count_q, br_count_d;
    logic [CNT_W-1:0]   br_taken_q, br_taken_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   next_pc;
    logic               take;
    logic               retire;

    pc_target_calc #(.W(WIDTH)) u_target_calc (
        .pc       (pc_q),
        .imm      (imm),
        .reg_val  (regVal),
        .jmp_en   (jmpEn),
        .jmp_reg  (jmpReg),
        .br_en    (brEn),
        .br_sel   (brSel),
        .pc_plus2 (pcPlus2),
        .next_pc  (next_pc),
        .take     (take)
    );

    // An instruction retires only while running and not held by a hazard.
    assign retire   = (state_q == RUN) && !stall;
    assign redirect = retire && !halt && take;

    assign pc      = pc_q;
    assign halted  = (state_q == HALTED);
    assign brCount = br_count_q;
    assign brTaken = br_taken_q;
    assign err     = err_q;

    // Next-state: everything holds unless an instruction retires.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        br_count_d = br_count_q;
        br_taken_d = br_taken_q;
        err_d      = err_q;
        if (retire) begin
            // The fault is recorded even when halt wins the cycle.
            if (brEn && jmpEn) begin
                err_d = 1'b1;
            end
            if (halt) begin
                state_d = HALTED;
            end else begin
                pc_d = next_pc;
                if (brEn && !jmpEn) begin
                    br_count_d = sat_inc(br_count_q);
                    if (brSel) begin
                        br_taken_d = sat_inc(br_taken_q);
                    end
                end
            end
        end
    end

    // State, PC, counters and fault register with immediate reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            br_count_q <= '0;
            br_taken_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values and simulation matches the synthesized registers.
            state_q    <= state_d;
            pc_q       <= pc_d;
            br_count_q <= br_count_d;
            br_taken_q <= br_taken_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter control stage sitting directly downstream of the branch-condition evaluator. Holds the fetch PC, selects the next PC from sequential, branch, PC-relative jump and register-indirect jump targets using the taken/not-taken decision, and enters a terminal halted state on HALT. Also keeps saturating counts of retired branches and taken branches, and records a sticky fault for illegal control combinations.

## Interface
Parameters:
- WIDTH, 16, datapath/PC width
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and counters this cycle (hazard)
- brEn  in  1  current instruction is a conditional branch
- brSel  in  1  branch condition true (from branch evaluator)
- jmpEn  in  1  current instruction is an unconditional jump
- jmpReg  in  1  with jmpEn: target is regVal+imm, else pcPlus2+imm
- halt  in  1  current instruction is HALT
- imm  in  WIDTH  sign-extended displacement
- regVal  in  WIDTH  register operand for indirect jump
- pc  out  WIDTH  current fetch PC (registered)
- pcPlus2  out  WIDTH  pc+2, combinational (link value)
- redirect  out  1  combinational: next PC is non-sequential
- halted  out  1  registered: in HALTED state
- brCount  out  16  branches retired, saturating
- brTaken  out  16  taken branches retired, saturating
- err  out  1  sticky: brEn and jmpEn seen together

## Operation
- States: RUN, HALTED. Reset → RUN. Only reset leaves HALTED.
- "Retire" = state RUN and stall low.
- Next PC (RUN, retire), priority order:
  - halt → pc (hold); state → HALTED
  - jmpEn & jmpReg → regVal + imm
  - jmpEn & ~jmpReg → pcPlus2 + imm
  - brEn & brSel → pcPlus2 + imm
  - otherwise → pcPlus2
- RUN with stall high, or HALTED: pc holds; counters hold; halt input ignored while stalled.
- All adds modulo 2^WIDTH; 16'hFFFE + 2 = 16'h0000, no flag.
- redirect = retire & ~halt & (jmpEn | (brEn & brSel)); low in HALTED or stalled.
- brCount increments on retire & brEn & ~jmpEn & ~halt; brTaken additionally requires brSel. Both saturate at 16'hFFFF.
- err set on retire & brEn & jmpEn (jump wins, branch not counted); cleared only by reset.
- halt together with brEn/jmpEn: halt wins; no redirect, no count, err still evaluated.

## Timing
- Reset (async, immediate): pc = RESET_PC, halted = 0, brCount = 0, brTaken = 0, err = 0, state RUN. Reset mid-stall or in HALTED behaves identically.
- First rising edge after rst deasserts is the first possible retire.
- pc, halted, counters, err update on the rising edge of the retiring cycle; visible next cycle (latency 1).
- pcPlus2 and redirect are combinational from pc/state/inputs, valid same cycle.
- halted rises the cycle after HALT retires; pc remains the HALT address indefinitely.

## Structure
- Shared package: WIDTH, RESET_PC default, state enum (RUN, HALTED), counter width/saturate constant.
- One combinational sub-module, pc_target_calc: computes pcPlus2, PC-relative target, indirect target and the selected next PC from the decoded controls; pc_ctrl owns state, PC register, counters and err.

## Test plan
- Reset then 3 idle retires (no controls): pc sequence 0000→0002→0004→0006; redirect 0; counters 0.
- pc=0010, brEn=1, brSel=1, imm=FFF8: next pc=000A, redirect=1, brCount=1, brTaken=1; repeat with brSel=0 → pc=000C, brCount+1 only.
- pc=0020, jmpEn=1, jmpReg=1, regVal=1000, imm=0004: next pc=1004; same with jmpReg=0, imm=0100 → 0122; counters unchanged.
- stall=1 for 3 cycles with brEn=1, brSel=1 at pc=0040: pc stays 0040, redirect 0, counters unchanged; on release pc→0042+imm.
- halt at pc=0050 with brEn=1, brSel=1: pc holds 0050, halted=1 next cycle, counters unchanged; further inputs ignored; async rst mid-cycle → pc=0000, halted=0 immediately.
- brEn=jmpEn=1, jmpReg=0, pc=0060, imm=0010: pc→0072, err=1 and stays 1; brCount preset to FFFF plus branch retire → remains FFFF.
